// File: rtl/raybox_buttons.sv
`default_nettype none
// ============================================================================
// Module   : raybox_buttons
// Purpose  : Input conditioner between the board's raw active-low pushbuttons
//            and the raybox core. It synchronises and debounces the four
//            direction buttons and the map key, then qualifies chords. The
//            opposing-pair chords K2+K3 and K1+K4 select debug modes. Every
//            other press becomes movement. No movement output glitches while
//            a chord is still being formed.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1  design clock (25 MHz)
//   reset_n   in   1  asynchronous active-low reset
//   k_n       in   4  raw buttons {K4,K3,K2,K1}, low = pressed
//   map_n     in   1  raw map key, low = pressed
//   moveF/L/R/B  out 1  registered movement commands, high = active
//   debugA..D    out 1  registered debug commands, high = active
//   show_map  out  1  debounced map key, high = pressed
//   state     out  3  current chord FSM state (for debug LEDs)
// ============================================================================
module raybox_buttons #(
    parameter int DEBOUNCE = 250000,   // cycles of disagreement before a flip
    parameter int CHORD    = 500000    // cycles spent qualifying a press
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] k_n,
    input  logic       map_n,
    output logic       moveF,
    output logic       moveL,
    output logic       moveR,
    output logic       moveB,
    output logic       debugA,
    output logic       debugB,
    output logic       debugC,
    output logic       debugD,
    output logic       show_map,
    output logic [2:0] state
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_NUM_IN = 5;
    localparam int c_DEB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int c_QUAL_W = (CHORD > 1) ? $clog2(CHORD) : 1;

    localparam logic [c_DEB_W-1:0]  c_DEB_MAX  = c_DEB_W'(DEBOUNCE - 1);
    localparam logic [c_QUAL_W-1:0] c_QUAL_MAX = c_QUAL_W'(CHORD - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUAL    = 3'd1,
        ST_MOVE    = 3'd2,
        ST_DBG1    = 3'd3,
        ST_DBG2    = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser. Both stages reset to 1 so that a reset looks
    // like "all buttons released" to the debouncers.
    // ------------------------------------------------------------------------
    logic [c_NUM_IN-1:0] w_raw;
    logic [c_NUM_IN-1:0] r_sync1;
    logic [c_NUM_IN-1:0] r_sync2;

    assign w_raw = {map_n, k_n};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-input debouncer. The counter tracks how many consecutive cycles the
    // synchronised value has disagreed with the debounced value. Any
    // agreement restarts the run, so a bounce shorter than DEBOUNCE cycles
    // never flips the output.
    // ------------------------------------------------------------------------
    logic [c_NUM_IN-1:0] w_deb;

    genvar gi;
    generate
        for (gi = 0; gi < c_NUM_IN; gi = gi + 1) begin : g_deb
            logic                r_deb;
            logic [c_DEB_W-1:0]  r_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_deb <= 1'b1;
                    r_cnt <= '0;
                end else if (r_sync2[gi] != r_deb) begin
                    if (r_cnt == c_DEB_MAX) begin
                        r_deb <= r_sync2[gi];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_deb[gi] = r_deb;
        end
    endgenerate

    // Pressed vector, active high: p[3]=K4, p[2]=K3, p[1]=K2, p[0]=K1.
    logic [3:0] w_p;
    logic       w_any;
    logic       w_chord_a;   // K3+K2 -> debug set 1
    logic       w_chord_b;   // K4+K1 -> debug set 2

    assign w_p       = ~w_deb[3:0];
    assign w_any     = |w_p;
    assign w_chord_a = w_p[2] & w_p[1];
    assign w_chord_b = w_p[3] & w_p[0];

    // ------------------------------------------------------------------------
    // Chord qualification FSM: state register
    // ------------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_next;
    logic [c_QUAL_W-1:0]   r_qcnt;
    logic [c_QUAL_W-1:0]   w_qcnt_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_qcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_qcnt  <= w_qcnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Chord qualification FSM: next-state logic. The qualification window is
    // not restarted by changes of p inside QUAL, so a second button of a
    // chord only has to land within CHORD cycles of the first.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_qcnt_next  = r_qcnt;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next = ST_QUAL;
                    w_qcnt_next  = '0;
                end
            end

            ST_QUAL: begin
                if (!w_any) begin
                    w_state_next = ST_IDLE;
                end else if (r_qcnt == c_QUAL_MAX) begin
                    if (w_chord_a) begin
                        w_state_next = ST_DBG1;
                    end else if (w_chord_b) begin
                        w_state_next = ST_DBG2;
                    end else begin
                        w_state_next = ST_MOVE;
                    end
                end else begin
                    w_qcnt_next = r_qcnt + 1'b1;
                end
            end

            ST_MOVE: begin
                if (!w_any) begin
                    w_state_next = ST_IDLE;
                end else if (w_chord_a || w_chord_b) begin
                    // A chord formed while moving: stop moving and re-qualify.
                    w_state_next = ST_QUAL;
                    w_qcnt_next  = '0;
                end
            end

            ST_DBG1: begin
                if (!w_chord_a) begin
                    w_state_next = ST_RELEASE;
                end
            end

            ST_DBG2: begin
                if (!w_chord_b) begin
                    w_state_next = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                // Wait for a full release so a leftover button is not
                // mistaken for a fresh movement press.
                if (!w_any) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_qcnt_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode from the next state, so the registered outputs change on
    // the same edge as the state. Move and debug outputs are exclusive by
    // construction because each is decoded from a different state.
    // ------------------------------------------------------------------------
    logic [3:0] w_move;    // {F,L,R,B}
    logic [3:0] w_debug;   // {A,B,C,D}

    always_comb begin
        w_move  = 4'b0000;
        w_debug = 4'b0000;

        case (w_state_next)
            ST_MOVE: begin
                w_move = {w_p[3], w_p[2], w_p[1], w_p[0]};
            end
            ST_DBG1: begin
                w_debug[3] = w_p[3];
                w_debug[2] = w_p[0];
            end
            ST_DBG2: begin
                w_debug[1] = w_p[1];
                w_debug[0] = w_p[2];
            end
            default: begin
                w_move  = 4'b0000;
                w_debug = 4'b0000;
            end
        endcase
    end

    logic [3:0] r_move;
    logic [3:0] r_debug;
    logic       r_show_map;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_move     <= 4'b0000;
            r_debug    <= 4'b0000;
            r_show_map <= 1'b0;
        end else begin
            r_move     <= w_move;
            r_debug    <= w_debug;
            r_show_map <= ~w_deb[4];
        end
    end

    assign moveF    = r_move[3];
    assign moveL    = r_move[2];
    assign moveR    = r_move[1];
    assign moveB    = r_move[0];
    assign debugA   = r_debug[3];
    assign debugB   = r_debug[2];
    assign debugC   = r_debug[1];
    assign debugD   = r_debug[0];
    assign show_map = r_show_map;
    assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_raybox_buttons.sv
`default_nettype none
// ============================================================================
// Module   : tb_raybox_buttons
// Purpose  : Self-checking bench for raybox_buttons with DEBOUNCE=4, CHORD=8.
//            A behavioural model predicts the full output vector for every
//            clock edge and queues it; a monitor on the falling edge pops and
//            compares. Directed scenarios add latency and state checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raybox_buttons;

    localparam int c_DEBOUNCE = 4;
    localparam int c_CHORD    = 8;

    // Spec state numbers
    localparam int c_IDLE = 0, c_QUAL = 1, c_MOVE = 2, c_DBG1 = 3, c_DBG2 = 4, c_REL = 5;

    logic       clk;
    logic       reset_n;
    logic [3:0] k_n;
    logic       map_n;
    logic       moveF, moveL, moveR, moveB;
    logic       debugA, debugB, debugC, debugD;
    logic       show_map;
    logic [2:0] state;

    int n_cmp = 0;
    int n_mis = 0;

    raybox_buttons #(
        .DEBOUNCE (c_DEBOUNCE),
        .CHORD    (c_CHORD)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .k_n      (k_n),
        .map_n    (map_n),
        .moveF    (moveF),
        .moveL    (moveL),
        .moveR    (moveR),
        .moveB    (moveB),
        .debugA   (debugA),
        .debugB   (debugB),
        .debugC   (debugC),
        .debugD   (debugD),
        .show_map (show_map),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {F,L,R,B, A,B,C,D, show_map, state[2:0]}
    function automatic logic [11:0] outs();
        return {moveF, moveL, moveR, moveB, debugA, debugB, debugC, debugD, show_map, state};
    endfunction

    // ------------------------------------------------------------------------
    // Reference model. A debounced input flips once the most recent DEBOUNCE
    // synchronised samples all disagree with it; the synchronised sample is
    // simply the raw value captured two edges earlier.
    // ------------------------------------------------------------------------
    logic [11:0] exp_q[$];
    logic [4:0]  m_raw[$];
    logic [4:0]  m_win[$];
    logic [4:0]  m_deb;
    int          m_st;
    int          m_age;

    always @(posedge clk) begin
        logic [3:0] p;
        logic [7:0] o;
        logic [4:0] smp;
        logic       all_diff;
        int         ns;
        int         nage;
        if (!reset_n) begin
            m_deb = 5'h1F;
            m_raw.delete();
            m_raw.push_back(5'h1F);
            m_raw.push_back(5'h1F);
            m_win.delete();
            m_st  = c_IDLE;
            m_age = 0;
            exp_q.push_back(12'h000);
        end else begin
            p    = ~m_deb[3:0];
            ns   = m_st;
            nage = m_age;
            case (m_st)
                c_IDLE: if (p != 0) begin ns = c_QUAL; nage = 0; end
                c_QUAL: begin
                    if (p == 0) ns = c_IDLE;
                    else if (m_age == c_CHORD - 1)
                        ns = (p[2] && p[1]) ? c_DBG1 : ((p[3] && p[0]) ? c_DBG2 : c_MOVE);
                    else nage = m_age + 1;
                end
                c_MOVE: begin
                    if (p == 0) ns = c_IDLE;
                    else if ((p[2] && p[1]) || (p[3] && p[0])) begin ns = c_QUAL; nage = 0; end
                end
                c_DBG1: if (!(p[2] && p[1])) ns = c_REL;
                c_DBG2: if (!(p[3] && p[0])) ns = c_REL;
                c_REL:  if (p == 0) ns = c_IDLE;
                default: ns = c_IDLE;
            endcase

            o = 8'h00;
            if (ns == c_MOVE) o[7:4] = p;
            if (ns == c_DBG1) begin o[3] = p[3]; o[2] = p[0]; end
            if (ns == c_DBG2) begin o[1] = p[1]; o[0] = p[2]; end
            exp_q.push_back({o, ~m_deb[4], 3'(ns)});

            smp = m_raw.pop_front();
            m_raw.push_back({map_n, k_n});
            m_win.push_back(smp);
            if (m_win.size() > c_DEBOUNCE) void'(m_win.pop_front());
            if (m_win.size() == c_DEBOUNCE) begin
                for (int i = 0; i < 5; i++) begin
                    all_diff = 1'b1;
                    foreach (m_win[j]) if (m_win[j][i] == m_deb[i]) all_diff = 1'b0;
                    if (all_diff) m_deb[i] = ~m_deb[i];
                end
            end
            m_st  = ns;
            m_age = nage;
        end
    end

    // Monitor: compare every registered output vector against the model.
    always @(negedge clk) begin
        logic [11:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (outs() !== e) begin
                n_mis++;
                $display("FAIL scoreboard t=%0t got=%b expected=%b", $time, outs(), e);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        n_cmp++;
        if (got < lo || got > hi) begin
            n_mis++;
            $display("FAIL %s got=%0d expected=%0d..%0d", name, got, lo, hi);
        end
    endtask

    // Count edges until the selected condition holds (bounded to 100 edges).
    task automatic wait_edges(input int sel, output int n);
        logic hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            case (sel)
                0:       hit = moveF;
                1:       hit = !moveF;
                default: hit = show_map;
            endcase
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int n;
        int bad;
        reset_n = 1'b0;
        k_n     = 4'hF;
        map_n   = 1'b1;
        idle_cycles(3);
        check("reset_outputs", outs(), 12'h000);
        reset_n = 1'b1;
        idle_cycles(2);

        // Single press K4: latency of moveF rising and falling
        k_n = 4'h7;
        wait_edges(0, n);
        check_range("press_latency", n, 14, 16);
        check("press_only_moveF", outs(), 12'h802);
        idle_cycles(5);
        k_n = 4'hF;
        wait_edges(1, n);
        check_range("release_latency", n, 6, 7);
        check("release_state", {9'h0, state}, 12'h000);
        idle_cycles(5);

        // Bounce on K1 every 3 cycles never reaches the FSM
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c % 3 == 0) k_n[0] = ~k_n[0];
            if (moveB || state != 3'd0) bad++;
        end
        k_n = 4'hF;
        check("bounce_ignored", 12'(bad), 12'h000);
        idle_cycles(10);

        // Chord K3 then K2 -> DBG1, K4 adds debugA, release K2 -> RELEASE
        k_n = 4'b1011;
        idle_cycles(4);
        k_n = 4'b1001;
        idle_cycles(40);
        check("chord_dbg1", outs(), 12'h003);
        k_n = 4'b0001;
        idle_cycles(20);
        check("dbg1_debugA", outs(), 12'h083);
        k_n = 4'b0011;
        idle_cycles(20);
        check("dbg1_release", outs(), 12'h005);
        k_n = 4'hF;
        idle_cycles(20);
        check("dbg1_all_released", outs(), 12'h000);

        // MOVE with K1, then K4 forms a chord -> QUAL -> DBG2, K2 -> debugC
        k_n = 4'b1110;
        idle_cycles(30);
        check("move_back", outs(), 12'h102);
        k_n = 4'b0110;
        idle_cycles(9);
        check("requalify", outs(), 12'h001);
        idle_cycles(11);
        check("chord_dbg2", outs(), 12'h004);
        k_n = 4'b0100;
        idle_cycles(20);
        check("dbg2_debugC", outs(), 12'h024);
        k_n = 4'hF;
        idle_cycles(30);

        // Map key during chord qualification
        k_n   = 4'b1011;
        map_n = 1'b0;
        wait_edges(2, n);
        check_range("map_latency", n, 7, 7);
        check("map_in_qual", outs(), 12'h009);
        k_n   = 4'hF;
        map_n = 1'b1;
        idle_cycles(30);

        // Asynchronous reset while moving forward
        k_n = 4'h7;
        idle_cycles(30);
        check("move_forward", outs(), 12'h802);
        #2 reset_n = 1'b0;
        #1 check("async_reset", outs(), 12'h000);
        idle_cycles(2);
        k_n     = 4'hF;
        reset_n = 1'b1;
        idle_cycles(5);

        // Randomised presses, holds and bounces
        for (int it = 0; it < 200; it++) begin
            @(negedge clk);
            k_n   = 4'($urandom);
            map_n = 1'($urandom);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            else idle_cycles($urandom_range(5, 30));
        end
        k_n   = 4'hF;
        map_n = 1'b1;
        idle_cycles(40);
        check("final_idle", outs(), 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
